ppg_beat_analyzer: RTL and testbench
====================================

# ppg_beat_analyzer

Reader of the two 20-bit filtered photoplethysmogram streams produced by the RED and IR FIR filters. It samples both streams once per filter strobe and runs a hysteresis peak/trough state machine on the IR channel. For every completed beat it reports the IR AC amplitude, the RED AC amplitude and the beat interval in samples, which are the raw inputs for the downstream SpO2 ratio and heart-rate computation.

## Interface
- HYST, 64: hysteresis, in LSBs, used for peak/trough declaration.
- MAX_INTERVAL, 1000: sample count without a trough that triggers a timeout.
- clk  input  1  system clock; the same clock that drives the controller.
- rst_n  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- CLK_Filter  input  1  filter sample strobe, generated in the clk domain. Not used as a clock.
- Out_IR_Filtered  input  20  unsigned IR filter output.
- Out_RED_Filtered  input  20  unsigned RED filter output.
- beat_valid  output  1  one-cycle pulse; the beat outputs are updated in this cycle.
- ir_ac  output  20  IR peak minus trough for the last reported beat.
- red_ac  output  20  RED maximum minus minimum over the last reported beat.
- beat_interval  output  12  samples between the last two confirmed troughs.
- no_pulse  output  1  high while no valid beat has been reported since reset or timeout.

## Operation
- **Sample accept.** CLK_Filter is registered every clk. An accept occurs in a cycle where CLK_Filter=1 and the registered copy=0. Both inputs are captured into 20-bit registers on that edge.
- **Per-accept actions.**
  - The sample counter `cnt` (12-bit, saturating) increments.
  - `red_max` and `red_min` update with the RED sample.
- **FSM states.**
  - ACQUIRE: on the first accept, load `ir_max`, `ir_min`, `red_max` and `red_min` with the sample; clear `armed`; go to RISING.
  - RISING: track `ir_max`. A peak is declared when `sample + HYST < ir_max`. Compare in 21 bits; no underflow is possible. On a peak: `ir_peak <= ir_max`, `ir_min <= sample`, go to FALLING.
  - FALLING: track `ir_min`. A trough is declared when `sample > ir_min + HYST` (21-bit compare). On a trough:
    - If `armed`: `ir_ac <= ir_peak - ir_min`, `red_ac <= red_max - red_min`, `beat_interval <= cnt`, assert `beat_valid`, clear `no_pulse`.
    - Always: set `armed`, `cnt <= 0`, `ir_max <= sample`, `red_max <= red_min <= RED sample`, go to RISING.
- **Beat-window tracking.** RED extremes include the trough sample of the current window.
- **Timeout.** When `cnt` reaches MAX_INTERVAL in RISING or FALLING without a trough: set `no_pulse`, go to ACQUIRE, clear `cnt`. The held beat outputs are not changed. If a trough and a timeout occur on the same sample, the trough wins.
- **Subtraction width.** All subtractions are 20-bit unsigned. The FSM guarantees that `peak > trough` and `red_max >= red_min`.
- **Reset values.**
  - beat_valid, ir_ac, red_ac and beat_interval are 0; no_pulse is 1.
  - State is ACQUIRE; `cnt`, `armed` and all trackers are 0.
  - Reset in any state, including mid-beat, restores these values on the next clk edge.

## Timing
- Cycle N is the accept cycle: the edge is detected and the samples are registered at the end of N.
- Compares, tracker updates and the state transition are registered at the end of N+1.
- beat_valid is high for exactly cycle N+2. ir_ac, red_ac and beat_interval change at the start of N+2 and hold until the next beat or reset.
- no_pulse falls in the same cycle as the first beat_valid. It rises the cycle after the timeout-triggering sample is processed (N+2).
- CLK_Filter held high for any number of cycles counts as one accept. The minimum accept spacing is 3 clk; strobes faster than that are outside spec.
- Only the first trough after ACQUIRE arms the block; it does not report. The first beat_valid is therefore at the second trough.

## Test plan
- **Triangle waveform.**
  - Stimulus: IR is a triangle 1000→2000→1000 in steps of 50 (40-sample period); RED is a triangle 500→800 in phase.
  - Required: the first beat_valid occurs at the second trough declaration (IR sample 1100 after the minimum). Values: ir_ac=1000, red_ac=300, beat_interval=40, no_pulse 1→0. Each subsequent beat repeats these values.
- **Noise rejection.** Stimulus: IR flat at 1500 with ±30 jitter for 999 accepts. Required: no beat_valid; no_pulse stays 1; the FSM stays RISING/FALLING with no declared peak.
- **Timeout.**
  - Stimulus: a locked triangle (as above), then IR held constant.
  - Required:
    - no_pulse rises after 1000 accepts counted from the last trough.
    - Outputs hold 1000/300/40.
    - When the triangle resumes, beat_valid fires only at the second new trough.
- **Strobe edge detection.** Stimulus: CLK_Filter held high for 10 clk, then low, then high for 1 clk. Required: exactly 2 accepts; `cnt` increments by 2.
- **Underflow guard.** Stimulus: IR rises to 30, then drops to 0. Required: no peak declared, since 0+64 < 30 is false; the state remains RISING.
- **Reset mid-beat.** Stimulus: rst_n low for 1 clk during FALLING, with ir_ac=1000 held. Required: the next cycle shows all outputs 0, no_pulse=1 and state ACQUIRE. Two further troughs are needed before beat_valid fires.

Source files
------------

// File: rtl/ppg_beat_analyzer.sv
// PPG beat analyzer: samples the filtered RED/IR streams on each filter strobe and
// runs an IR hysteresis peak/trough FSM, reporting AC amplitudes and beat interval.
module ppg_beat_analyzer #(
  parameter int unsigned HYST         = 64,
  parameter int unsigned MAX_INTERVAL = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CLK_Filter,
  input  logic [19:0] Out_IR_Filtered,
  input  logic [19:0] Out_RED_Filtered,
  output logic        beat_valid,
  output logic [19:0] ir_ac,
  output logic [19:0] red_ac,
  output logic [11:0] beat_interval,
  output logic        no_pulse
);

  localparam int unsigned DW = 20;
  localparam int unsigned CW = 12;

  localparam logic [1:0] S_ACQUIRE = 2'd0;
  localparam logic [1:0] S_RISING  = 2'd1;
  localparam logic [1:0] S_FALLING = 2'd2;

  logic          strb_q, strb_d;
  logic          acc_q, acc_d;
  logic [DW-1:0] ir_s_q, ir_s_d, red_s_q, red_s_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] ir_max_q, ir_max_d, ir_min_q, ir_min_d, ir_peak_q, ir_peak_d;
  logic [DW-1:0] red_max_q, red_max_d, red_min_q, red_min_d;
  logic          beat_valid_q, beat_valid_d;
  logic [DW-1:0] ir_ac_q, ir_ac_d, red_ac_q, red_ac_d;
  logic [CW-1:0] beat_interval_q, beat_interval_d;
  logic          no_pulse_q, no_pulse_d;

  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] red_max_upd, red_min_upd;
  logic [DW:0]   ir_ext, hyst_ext;
  logic          peak, trough, timeout;

  always_comb begin
    strb_d          = CLK_Filter;
    acc_d           = CLK_Filter & ~strb_q;
    ir_s_d          = ir_s_q;
    red_s_d         = red_s_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    armed_d         = armed_q;
    ir_max_d        = ir_max_q;
    ir_min_d        = ir_min_q;
    ir_peak_d       = ir_peak_q;
    red_max_d       = red_max_q;
    red_min_d       = red_min_q;
    beat_valid_d    = 1'b0;
    ir_ac_d         = ir_ac_q;
    red_ac_d        = red_ac_q;
    beat_interval_d = beat_interval_q;
    no_pulse_d      = no_pulse_q;

    cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    red_max_upd = (red_s_q > red_max_q) ? red_s_q : red_max_q;
    red_min_upd = (red_s_q < red_min_q) ? red_s_q : red_min_q;
    ir_ext      = {1'b0, ir_s_q};
    hyst_ext    = (DW+1)'(HYST);
    peak        = (state_q == S_RISING)  && ((ir_ext + hyst_ext) < {1'b0, ir_max_q});
    trough      = (state_q == S_FALLING) && (ir_ext > ({1'b0, ir_min_q} + hyst_ext));
    timeout     = (state_q != S_ACQUIRE) && (32'(cnt_inc) >= MAX_INTERVAL);

    if (acc_d) begin
      ir_s_d  = Out_IR_Filtered;
      red_s_d = Out_RED_Filtered;
    end

    // Work on the sample captured on the previous cycle's accept
    if (acc_q) begin
      cnt_d     = cnt_inc;
      red_max_d = red_max_upd;
      red_min_d = red_min_upd;
      if (state_q == S_ACQUIRE) begin
        ir_max_d  = ir_s_q;
        ir_min_d  = ir_s_q;
        red_max_d = red_s_q;
        red_min_d = red_s_q;
        armed_d   = 1'b0;
        state_d   = S_RISING;
      end else if (trough) begin
        if (armed_q) begin
          ir_ac_d         = ir_peak_q - ir_min_q;
          red_ac_d        = red_max_upd - red_min_upd;
          beat_interval_d = cnt_inc;
          beat_valid_d    = 1'b1;
          no_pulse_d      = 1'b0;
        end
        armed_d   = 1'b1;
        cnt_d     = '0;
        ir_max_d  = ir_s_q;
        red_max_d = red_s_q;
        red_min_d = red_s_q;
        state_d   = S_RISING;
      end else if (timeout) begin
        no_pulse_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_ACQUIRE;
      end else if (state_q == S_RISING) begin
        if (peak) begin
          ir_peak_d = ir_max_q;
          ir_min_d  = ir_s_q;
          state_d   = S_FALLING;
        end else if (ir_s_q > ir_max_q) begin
          ir_max_d = ir_s_q;
        end
      end else if (state_q == S_FALLING) begin
        if (ir_s_q < ir_min_q) ir_min_d = ir_s_q;
      end else begin
        state_d = S_ACQUIRE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_q          <= 1'b0;
      acc_q           <= 1'b0;
      ir_s_q          <= '0;
      red_s_q         <= '0;
      state_q         <= S_ACQUIRE;
      cnt_q           <= '0;
      armed_q         <= 1'b0;
      ir_max_q        <= '0;
      ir_min_q        <= '0;
      ir_peak_q       <= '0;
      red_max_q       <= '0;
      red_min_q       <= '0;
      beat_valid_q    <= 1'b0;
      ir_ac_q         <= '0;
      red_ac_q        <= '0;
      beat_interval_q <= '0;
      no_pulse_q      <= 1'b1;
    end else begin
      strb_q          <= strb_d;
      acc_q           <= acc_d;
      ir_s_q          <= ir_s_d;
      red_s_q         <= red_s_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      armed_q         <= armed_d;
      ir_max_q        <= ir_max_d;
      ir_min_q        <= ir_min_d;
      ir_peak_q       <= ir_peak_d;
      red_max_q       <= red_max_d;
      red_min_q       <= red_min_d;
      beat_valid_q    <= beat_valid_d;
      ir_ac_q         <= ir_ac_d;
      red_ac_q        <= red_ac_d;
      beat_interval_q <= beat_interval_d;
      no_pulse_q      <= no_pulse_d;
    end
  end

  assign beat_valid    = beat_valid_q;
  assign ir_ac         = ir_ac_q;
  assign red_ac        = red_ac_q;
  assign beat_interval = beat_interval_q;
  assign no_pulse      = no_pulse_q;

endmodule

// File: tb/tb_ppg_beat_analyzer.sv
// Scoreboard bench for ppg_beat_analyzer: a sample-stream reference model queues
// expected beats, and a monitor checks every beat_valid against that queue.
module tb_ppg_beat_analyzer;

  localparam int HYST = 64;
  localparam int MAXI = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CLK_Filter = 1'b0;
  logic [19:0] ir_in = '0;
  logic [19:0] red_in = '0;
  logic        beat_valid;
  logic [19:0] ir_ac;
  logic [19:0] red_ac;
  logic [11:0] beat_interval;
  logic        no_pulse;

  ppg_beat_analyzer #(.HYST(HYST), .MAX_INTERVAL(MAXI)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .CLK_Filter       (CLK_Filter),
    .Out_IR_Filtered  (ir_in),
    .Out_RED_Filtered (red_in),
    .beat_valid       (beat_valid),
    .ir_ac            (ir_ac),
    .red_ac           (red_ac),
    .beat_interval    (beat_interval),
    .no_pulse         (no_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  int beats_exp = 0;
  int beats_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ir_ac;
    int red_ac;
    int interval;
  } beat_t;
  beat_t exp_q[$];

  // Reference model: phase 0 = waiting for first sample, 1 = seeking peak, 2 = seeking trough
  int m_phase, m_hi, m_lo, m_peak, m_since;
  bit m_armed, m_no_pulse;
  int red_win[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_hi = 0; m_lo = 0; m_peak = 0; m_since = 0;
    m_armed = 1'b0; m_no_pulse = 1'b1;
    red_win.delete();
  endfunction

  function automatic void model_step(input int ir, input int red);
    int rmax, rmin;
    beat_t b;
    if (m_phase == 0) begin
      m_phase = 1; m_hi = ir; m_lo = ir; m_armed = 1'b0; m_since = 1;
      red_win.delete(); red_win.push_back(red);
      return;
    end
    m_since++;
    red_win.push_back(red);
    if (m_phase == 2 && ir > m_lo + HYST) begin
      if (m_armed) begin
        rmax = red_win[0]; rmin = red_win[0];
        foreach (red_win[i]) begin
          if (red_win[i] > rmax) rmax = red_win[i];
          if (red_win[i] < rmin) rmin = red_win[i];
        end
        b.ir_ac = m_peak - m_lo; b.red_ac = rmax - rmin; b.interval = m_since;
        exp_q.push_back(b);
        beats_exp++;
        m_no_pulse = 1'b0;
      end
      m_armed = 1'b1; m_since = 0; m_hi = ir; m_phase = 1;
      red_win.delete(); red_win.push_back(red);
    end else if (m_since >= MAXI) begin
      m_no_pulse = 1'b1; m_phase = 0; m_since = 0;
    end else if (m_phase == 1) begin
      if (ir + HYST < m_hi) begin
        m_peak = m_hi; m_lo = ir; m_phase = 2;
      end else if (ir > m_hi) m_hi = ir;
    end else if (ir < m_lo) m_lo = ir;
  endfunction

  // Monitor: every beat_valid must match the oldest expected beat, two cycles after its accept
  always @(negedge clk) begin
    if (rst_n && beat_valid === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("ir_ac", int'(ir_ac), e.ir_ac);
        check("red_ac", int'(red_ac), e.red_ac);
        check("beat_interval", int'(beat_interval), e.interval);
        check("no_pulse_at_beat", int'(no_pulse), 0);
        check("beat_latency", cyc, last_acc_cyc + 1);
      end
    end
  end

  task automatic send(input int ir, input int red, input int hold);
    int n;
    model_step(ir, red);
    ir_in = 20'(ir);
    red_in = 20'(red);
    CLK_Filter = 1'b1;
    last_acc_cyc = cyc + 1;
    n = (hold > 2) ? hold + 1 : 3;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == hold) CLK_Filter = 1'b0;
      if (i == 2) check("no_pulse", int'(no_pulse), int'(m_no_pulse));
    end
  endtask

  task automatic send_tri(input int k, input int hold);
    int p, t;
    p = k % 40;
    t = (p <= 20) ? p : 40 - p;
    send(1000 + 50 * t, 500 + 15 * t, ((k % 40) == 10) ? hold : 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    CLK_Filter = 1'b0;
    @(negedge clk);
    check("rst_beat_valid", int'(beat_valid), 0);
    check("rst_ir_ac", int'(ir_ac), 0);
    check("rst_red_ac", int'(red_ac), 0);
    check("rst_beat_interval", int'(beat_interval), 0);
    check("rst_no_pulse", int'(no_pulse), 1);
    check("rst_pending_beats", exp_q.size(), 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_ir_ac"}, int'(ir_ac), 1000);
    check({tag, "_red_ac"}, int'(red_ac), 300);
    check({tag, "_interval"}, int'(beat_interval), 40);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Locked triangle: troughs at k=42 (arm), 82, 122, 162
    for (int k = 0; k <= 200; k++) send_tri(k, 1);
    check_held("tri");
    check("tri_no_pulse", int'(no_pulse), 0);
    check("tri_beats", beats_seen, 3);

    // Flat IR until timeout, then resume
    for (int i = 0; i < 1000; i++) send(1000, 500, 1);
    check("timeout_no_pulse", int'(no_pulse), 1);
    check_held("timeout_hold");
    for (int k = 0; k <= 81; k++) send_tri(k, 1);
    check("resume_first_trough_silent", beats_seen, 3);
    for (int k = 82; k <= 120; k++) send_tri(k, 1);
    check("resume_beats", beats_seen, 4);

    // Long-held strobe inside each period must count as a single accept
    for (int k = 121; k <= 200; k++) send_tri(k, 10);
    check_held("strobe");

    // Reset while seeking a trough
    for (int k = 201; k <= 230; k++) send_tri(k, 1);
    do_reset();
    for (int k = 231; k <= 330; k++) send_tri(k, 1);

    // Jitter within the hysteresis band never produces a beat
    do_reset();
    begin
      int seen0;
      seen0 = beats_seen;
      for (int i = 0; i < 999; i++)
        send(1470 + int'($urandom_range(60)), 500 + int'($urandom_range(300)), 1);
      check("noise_beats", beats_seen, seen0);
      check("noise_no_pulse", int'(no_pulse), 1);
    end

    // Low values near zero must not fake a peak; a following waveform is still tracked
    do_reset();
    send(0, 500, 1); send(10, 500, 1); send(20, 500, 1); send(30, 500, 1);
    send(0, 500, 1); send(0, 500, 1);
    for (int k = 0; k <= 90; k++) send_tri(k, 1);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("beat_count", beats_seen, beats_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
